// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the writeback/commit stage.
//   DEST_GPR / DEST_PC / DEST_RAM : one-hot {store, branch, writeback} codes
//   wb_state_t                    : commit FSM states
//   wb_entry_t                    : one buffered ALU result
// WB_RD_W / WB_ADDR_W set the storage width of the entry fields; the
// writeback_commit REG_W / ADDR_W parameters must not exceed them.
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [2:0] DEST_GPR = 3'b001;
   localparam logic [2:0] DEST_PC  = 3'b010;
   localparam logic [2:0] DEST_RAM = 3'b100;

   localparam int WB_RD_W   = 4;
   localparam int WB_ADDR_W = 16;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      RAM_WAIT = 1'b1
   } wb_state_t;

   typedef struct packed {
      logic [2:0]           dest;
      logic [31:0]          data;
      logic [WB_RD_W-1:0]   rd;
      logic [WB_ADDR_W-1:0] addr;
   } wb_entry_t;

   // True for the two single-cycle register-style destinations.
   function automatic logic dest_is_reg(input logic [2:0] dest);
      return (dest == DEST_GPR) || (dest == DEST_PC);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO of wb_entry_t. Simultaneous push and pop are allowed.
// Push while full and pop while empty are ignored. DEPTH must be a power of
// two so pointers wrap naturally.
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   : write request and entry
//   pop, rdata    : read request and head entry (valid while !empty)
//   full, empty   : status flags derived from the registered count
//   count         : number of stored entries
// -----------------------------------------------------------------------------
module wb_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  wb_entry_t              wdata,
   input  logic                   pop,
   output wb_entry_t              rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   wb_entry_t        mem_r [DEPTH];
   logic [PTR_W-1:0] wptr_r;
   logic [PTR_W-1:0] rptr_r;
   logic [PTR_W:0]   count_r;
   logic             push_s;
   logic             pop_s;

   assign push_s = push && !full;
   assign pop_s  = pop && !empty;

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_r  <= PTR_W'(0);
         rptr_r  <= PTR_W'(0);
         count_r <= (PTR_W+1)'(0);
      end else begin
         if (push_s) begin
            wptr_r <= wptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rptr_r <= rptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (PTR_W+1)'(1);
            2'b01:   count_r <= count_r - (PTR_W+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wptr_r] <= wdata;
      end
   end

   assign rdata = mem_r[rptr_r];
   assign full  = (count_r == (PTR_W+1)'(DEPTH));
   assign empty = (count_r == (PTR_W+1)'(0));
   assign count = count_r;

endmodule

// File: rtl/writeback_commit.sv
// -----------------------------------------------------------------------------
// writeback_commit
// Buffers ALU results in a FIFO and commits each one to exactly one
// destination: GPR write port, PC load, or data-RAM write (req/ack).
// Illegal destination codes are dropped with a one-cycle bad_dest pulse.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid/in_ready              : upstream handshake (in_ready = count<DEPTH)
//   in_store/in_branch/in_writeback: one-hot destination select
//   in_data, in_rd, in_addr        : ALU result, GPR index, RAM address
//   gpr_we, gpr_waddr, gpr_wdata   : one-cycle GPR write
//   pc_load, pc_value              : one-cycle PC load
//   ram_req, ram_ack, ram_addr, ram_wdata : RAM write, req held until ack
//   bad_dest                       : illegal destination dropped
//   busy                           : entries queued or RAM write pending
// Configuration macro: WB_BYPASS_EN -- when defined, a GPR/PC push that
// arrives while the FIFO is empty and the FSM is idle skips the FIFO and
// strobes one cycle earlier.
// -----------------------------------------------------------------------------
module writeback_commit
   import cpu_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int REG_W  = 4,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_store,
   input  logic              in_branch,
   input  logic              in_writeback,
   input  logic [31:0]       in_data,
   input  logic [REG_W-1:0]  in_rd,
   input  logic [ADDR_W-1:0] in_addr,
   output logic              gpr_we,
   output logic [REG_W-1:0]  gpr_waddr,
   output logic [31:0]       gpr_wdata,
   output logic              pc_load,
   output logic [31:0]       pc_value,
   output logic              ram_req,
   input  logic              ram_ack,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic              bad_dest,
   output logic              busy
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   wb_state_t         state_r, state_d;
   wb_entry_t         in_entry_s, head_s;
   logic              fifo_full_s, fifo_empty_s;
   logic [CNT_W-1:0]  fifo_count_s;
   logic              push_s, fifo_push_s, pop_s, bypass_s;

   logic              gpr_we_r, gpr_we_d;
   logic [REG_W-1:0]  gpr_waddr_r, gpr_waddr_d;
   logic [31:0]       gpr_wdata_r, gpr_wdata_d;
   logic              pc_load_r, pc_load_d;
   logic [31:0]       pc_value_r, pc_value_d;
   logic              ram_req_r, ram_req_d;
   logic [ADDR_W-1:0] ram_addr_r, ram_addr_d;
   logic [31:0]       ram_wdata_r, ram_wdata_d;
   logic              bad_dest_r, bad_dest_d;

   // Pack the incoming result into a FIFO entry.
   always_comb begin
      in_entry_s      = '0;
      in_entry_s.dest = {in_store, in_branch, in_writeback};
      in_entry_s.data = in_data;
      in_entry_s.rd   = WB_RD_W'(in_rd);
      in_entry_s.addr = WB_ADDR_W'(in_addr);
   end

   assign in_ready    = !fifo_full_s;
   assign push_s      = in_valid && !fifo_full_s;
   assign fifo_push_s = push_s && !bypass_s;

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push_s),
      .wdata (in_entry_s),
      .pop   (pop_s),
      .rdata (head_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   // Next-state and next-output logic; data buses hold unless re-targeted.
   always_comb begin
      state_d     = state_r;
      pop_s       = 1'b0;
      bypass_s    = 1'b0;
      gpr_we_d    = 1'b0;
      gpr_waddr_d = gpr_waddr_r;
      gpr_wdata_d = gpr_wdata_r;
      pc_load_d   = 1'b0;
      pc_value_d  = pc_value_r;
      ram_req_d   = ram_req_r;
      ram_addr_d  = ram_addr_r;
      ram_wdata_d = ram_wdata_r;
      bad_dest_d  = 1'b0;
      case (state_r)
         IDLE: begin
            if (!fifo_empty_s) begin
               pop_s = 1'b1;
               case (head_s.dest)
                  DEST_GPR: begin
                     gpr_we_d    = 1'b1;
                     gpr_waddr_d = head_s.rd[REG_W-1:0];
                     gpr_wdata_d = head_s.data;
                  end
                  DEST_PC: begin
                     pc_load_d  = 1'b1;
                     pc_value_d = head_s.data;
                  end
                  DEST_RAM: begin
                     ram_req_d   = 1'b1;
                     ram_addr_d  = head_s.addr[ADDR_W-1:0];
                     ram_wdata_d = head_s.data;
                     state_d     = RAM_WAIT;
                  end
                  default: begin
                     bad_dest_d = 1'b1;
                  end
               endcase
            end else begin
`ifdef WB_BYPASS_EN
               // Empty and idle: a GPR/PC result commits straight from input.
               if (push_s && dest_is_reg(in_entry_s.dest)) begin
                  bypass_s = 1'b1;
                  if (in_entry_s.dest == DEST_GPR) begin
                     gpr_we_d    = 1'b1;
                     gpr_waddr_d = in_rd;
                     gpr_wdata_d = in_data;
                  end else begin
                     pc_load_d  = 1'b1;
                     pc_value_d = in_data;
                  end
               end else begin
                  bypass_s = 1'b0;
               end
`else
               bypass_s = 1'b0;
`endif
            end
         end
         RAM_WAIT: begin
            // No pop here: the next entry goes on the edge after ack.
            if (ram_ack) begin
               ram_req_d = 1'b0;
               state_d   = IDLE;
            end else begin
               ram_req_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         gpr_we_r    <= 1'b0;
         gpr_waddr_r <= REG_W'(0);
         gpr_wdata_r <= 32'h0000_0000;
         pc_load_r   <= 1'b0;
         pc_value_r  <= 32'h0000_0000;
         ram_req_r   <= 1'b0;
         ram_addr_r  <= ADDR_W'(0);
         ram_wdata_r <= 32'h0000_0000;
         bad_dest_r  <= 1'b0;
      end else begin
         state_r     <= state_d;
         gpr_we_r    <= gpr_we_d;
         gpr_waddr_r <= gpr_waddr_d;
         gpr_wdata_r <= gpr_wdata_d;
         pc_load_r   <= pc_load_d;
         pc_value_r  <= pc_value_d;
         ram_req_r   <= ram_req_d;
         ram_addr_r  <= ram_addr_d;
         ram_wdata_r <= ram_wdata_d;
         bad_dest_r  <= bad_dest_d;
      end
   end

   assign gpr_we    = gpr_we_r;
   assign gpr_waddr = gpr_waddr_r;
   assign gpr_wdata = gpr_wdata_r;
   assign pc_load   = pc_load_r;
   assign pc_value  = pc_value_r;
   assign ram_req   = ram_req_r;
   assign ram_addr  = ram_addr_r;
   assign ram_wdata = ram_wdata_r;
   assign bad_dest  = bad_dest_r;
   assign busy      = (fifo_count_s != CNT_W'(0)) || (state_r == RAM_WAIT);

endmodule

// File: doc/writeback_commit.md
# writeback_commit

Commit stage on the far side of the ALU output routing. Accepts ALU results tagged with the decoder's one-hot `{store, branch, writeback}` destination select, buffers them in a small FIFO, and drains each entry to exactly one destination. Destinations are a GPR write port (single-cycle), a program-counter load (single-cycle), or a data-RAM write with req/ack handshake (multi-cycle). It decouples ALU issue from RAM stalls and flags illegal destination encodings instead of silently holding stale values.

## Interface
- `DEPTH`, 2: FIFO entries (power of two, ≥2)
- `REG_W`, 4: GPR index width
- `ADDR_W`, 16: RAM address width
- `clk` in 1: sole clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `in_valid` in 1: upstream result valid
- `in_ready` out 1: FIFO can accept; `in_ready = (count < DEPTH)`, from registered count only
- `in_store` in 1: destination RAM
- `in_branch` in 1: destination PC
- `in_writeback` in 1: destination GPR
- `in_data` in 32: ALU result
- `in_rd` in REG_W: GPR index
- `in_addr` in ADDR_W: RAM address
- `gpr_we` out 1: one-cycle GPR write strobe
- `gpr_waddr` out REG_W; `gpr_wdata` out 32
- `pc_load` out 1: one-cycle PC load strobe; `pc_value` out 32
- `ram_req` out 1: RAM write request, held until ack
- `ram_ack` in 1: RAM accepted write
- `ram_addr` out ADDR_W; `ram_wdata` out 32
- `bad_dest` out 1: one-cycle pulse, illegal destination dropped
- `busy` out 1: `count != 0 || state == RAM_WAIT`

## Operation
- Push on `in_valid && in_ready`. Entry fields are dest[2:0], data, rd, addr. Simultaneous push and pop are allowed.
- Destination encoding: 3'b001 GPR, 3'b010 PC, 3'b100 RAM. Any other value (000, multi-hot) is illegal.
- FSM states:
  - IDLE:
    - FIFO non-empty: pop head.
    - GPR head: `gpr_we`=1 next cycle with waddr/wdata. Stay IDLE.
    - PC head: `pc_load`=1 next cycle with `pc_value`. Stay IDLE.
    - RAM head: `ram_req`=1, addr/wdata latched. Go to RAM_WAIT.
    - Illegal head: `bad_dest`=1, entry discarded, no other strobe. Stay IDLE.
  - RAM_WAIT:
    - `ram_req`, `ram_addr` and `ram_wdata` are stable.
    - No pop while here.
    - On `ram_ack` sampled high: `ram_req` drops next cycle and state goes to IDLE. The next entry is popped on the following edge, so there is one bubble after each RAM write.
- `ram_ack` is ignored while `ram_req`=0.
- All data outputs are registered. Data buses hold their last value when strobes are low.
- Commit order equals push order. No reordering across destinations.

## Timing
- Reset value of all outputs: 0, except `in_ready`=1. FIFO is emptied (count=0, pointers 0). State is IDLE.
- GPR/PC latency: push accepted at edge E, strobe high in the cycle after edge E+1. Throughput is one commit per cycle.
- RAM latency: `ram_req` high after E+1. Minimum 1 cycle high if `ram_ack` is already high at E+2.
- Full FIFO: `in_ready`=0, and `in_valid` is ignored. A pop in the same cycle does not raise `in_ready` until the next cycle.
- Pointers wrap modulo DEPTH.
- Reset mid-RAM_WAIT: `ram_req` drops after the reset edge. The pending write and all queued entries are lost.
- `rst` overrides push, pop and ack in the same cycle.

## Configuration
- `WB_BYPASS_EN` defined:
  - Condition: FIFO empty, state IDLE, and an accepted push with GPR or PC destination.
  - Effect: the push skips the FIFO. The strobe is high in the cycle right after edge E, giving latency 0 extra cycles.
  - RAM and illegal pushes still go through the FIFO.
- `WB_BYPASS_EN` undefined: every entry goes through the FIFO, with the latency stated above.

## Structure
- Shared package `cpu_pkg`:
  - destination constants `DEST_GPR`, `DEST_PC`, `DEST_RAM`
  - `wb_state_t` enum {IDLE, RAM_WAIT}
  - `wb_entry_t` struct {dest, data, rd, addr}
- Sub-module `wb_fifo`: synchronous FIFO of `wb_entry_t` with count, push/pop, full/empty. The FSM and output registers stay in `writeback_commit`.

## Test plan
- Reset, then push GPR {001, 0xDEADBEEF, rd=5}. Expect `gpr_we`=1 for exactly one cycle with waddr=5 and wdata=0xDEADBEEF, one cycle after acceptance (same edge with `WB_BYPASS_EN`). `busy` returns to 0.
- Push RAM {100, 0x12345678, addr=0x00A0} with `ram_ack` held low for 4 cycles, then high for 1. Expect `ram_req` high for 5 cycles with constant addr/data, then low. No pop during the stall.
- Back-to-back pushes GPR rd=1, PC 0x400, GPR rd=2 with no stall. Expect the `gpr_we`, `pc_load`, `gpr_we` strobes on consecutive cycles in push order.
- Push a RAM write while ack is stalled, then push DEPTH more entries. Expect `in_ready`=0 after DEPTH entries and extra `in_valid` ignored. After ack, entries drain in order and `in_ready` returns to 1.
- Push dest 000, then 011, then GPR rd=3. Expect two `bad_dest` pulses, no GPR/PC/RAM strobes for the first two entries, then a normal GPR write to rd=3.
- Assert `rst` for 1 cycle during RAM_WAIT with 1 entry queued. Expect `ram_req`=0, `busy`=0 and `in_ready`=1 after the edge. The queued entry is never committed.
